// File: rtl/bttn_scheduler.sv
// Button panel front end: sync + debounce four raw buttons on a shared tick,
// queue presses as commands and offer them round-robin over valid/ready.
module bttn_scheduler #(
    parameter int TICK_MAX    = 50000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] botones,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_id,
    output logic       btn_rst,
    output logic [3:0] pending,
    output logic       evt_drop,
    output logic       dbg_arb_state
);

    // Handshake: cmd_valid/cmd_id stay stable until the cycle cmd_ready is
    // high (valid & ready on a rising edge = transfer); the only withdrawal
    // of cmd_valid without a transfer is a long-press game reset.

    localparam int TW = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int DW = $clog2(DEBOUNCE_MS + 1);
    localparam int HW = $clog2(LONG_MS + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_MAX - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_MS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_MS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_MS - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } arb_state_e;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;
    logic [3:0]    sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]    db_q, db_d, db_prev_q, db_prev_d;
    logic [DW-1:0] db_cnt_q [4];
    logic [DW-1:0] db_cnt_d [4];
    logic [HW-1:0] hold_q, hold_d;
    logic          long_seen_q, long_seen_d;
    logic          fire;
    logic [3:1]    rise;
    logic          fall0;
    logic [3:0]    set_req, hs_mask;
    logic          hs;
    logic [3:0]    pending_q, pending_d;
    logic          drop_q, drop_d;
    logic          btn_rst_q, btn_rst_d;
    arb_state_e    state_q, state_d;
    logic          valid_q, valid_d;
    logic [1:0]    id_q, id_d;
    logic [1:0]    last_q, last_d;
    logic [1:0]    pick, pick_idx;
    logic          found;

    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
        sync1_d    = botones;
        sync2_d    = sync1_q;
        db_prev_d  = db_q;
    end

    // A level is accepted only after DEBOUNCE_MS consecutive disagreeing ticks.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            if (tick) begin
                if (sync2_q[i] != db_q[i]) begin
                    if (db_cnt_q[i] == DB_LAST) begin
                        db_d[i]     = ~db_q[i];
                        db_cnt_d[i] = '0;
                    end else begin
                        db_cnt_d[i] = db_cnt_q[i] + DW'(1);
                    end
                end else begin
                    db_cnt_d[i] = '0;
                end
            end
        end
    end

    always_comb begin
        rise  = db_q[3:1] & ~db_prev_q[3:1];
        fall0 = db_prev_q[0] & ~db_q[0];
    end

    // Hold counter saturates at LONG_MS so the reset fires once per hold.
    always_comb begin
        hold_d      = hold_q;
        fire        = 1'b0;
        long_seen_d = long_seen_q;
        if (!db_q[0]) begin
            hold_d = '0;
        end else if (tick && (hold_q != HOLD_MAX)) begin
            hold_d = hold_q + HW'(1);
            fire   = (hold_q == HOLD_LAST);
        end
        if (fire) begin
            long_seen_d = 1'b1;
        end
        if (fall0) begin
            long_seen_d = 1'b0;
        end
        btn_rst_d = fire;
    end

    always_comb begin
        set_req   = {rise, fall0 & ~long_seen_q};
        hs        = valid_q & cmd_ready;
        hs_mask   = hs ? (4'b0001 << id_q) : 4'b0000;
        pending_d = pending_q & ~hs_mask;
        drop_d    = 1'b0;
        if (fire) begin
            pending_d = 4'b0000;
        end else begin
            pending_d = pending_d | set_req;
            // A press landing on the bit being handed over this cycle is a new command.
            drop_d    = |(set_req & pending_q & ~hs_mask);
        end
    end

    always_comb begin
        pick     = last_q;
        found    = 1'b0;
        pick_idx = last_q;
        for (int k = 1; k <= 4; k++) begin
            pick_idx = last_q + 2'(k);
            if (!found && pending_q[pick_idx]) begin
                pick  = pick_idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (!fire && (pending_q != 4'b0000)) begin
                    id_d    = pick;
                    valid_d = 1'b1;
                    state_d = ST_OFFER;
                end
            end
            ST_OFFER: begin
                if (hs) begin
                    last_d = id_q;
                end
                if (hs || fire) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_q  <= '0;
            sync1_q     <= 4'b0000;
            sync2_q     <= 4'b0000;
            db_q        <= 4'b0000;
            db_prev_q   <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                db_cnt_q[i] <= '0;
            end
            hold_q      <= '0;
            long_seen_q <= 1'b0;
            pending_q   <= 4'b0000;
            drop_q      <= 1'b0;
            btn_rst_q   <= 1'b0;
            state_q     <= ST_IDLE;
            valid_q     <= 1'b0;
            id_q        <= 2'd0;
            last_q      <= 2'd3;
        end else begin
            tick_cnt_q  <= tick_cnt_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            db_q        <= db_d;
            db_prev_q   <= db_prev_d;
            db_cnt_q    <= db_cnt_d;
            hold_q      <= hold_d;
            long_seen_q <= long_seen_d;
            pending_q   <= pending_d;
            drop_q      <= drop_d;
            btn_rst_q   <= btn_rst_d;
            state_q     <= state_d;
            valid_q     <= valid_d;
            id_q        <= id_d;
            last_q      <= last_d;
        end
    end

    assign cmd_valid     = valid_q;
    assign cmd_id        = id_q;
    assign btn_rst       = btn_rst_q;
    assign pending       = pending_q;
    assign evt_drop      = drop_q;
    assign dbg_arb_state = state_q;

endmodule

// File: tb/tb_bttn_scheduler.sv
// Directed and randomized bench for bttn_scheduler against a press-level
// model: accepted presses, drop count, reset pulses and round-robin order.
module tb_bttn_scheduler;

    localparam int TICK_MAX    = 4;
    localparam int DEBOUNCE_MS = 3;
    localparam int LONG_MS     = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] botones = 4'b0000;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       btn_rst;
    logic [3:0] pending;
    logic       evt_drop;
    logic       dbg_arb_state;

    bttn_scheduler #(
        .TICK_MAX   (TICK_MAX),
        .DEBOUNCE_MS(DEBOUNCE_MS),
        .LONG_MS    (LONG_MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .botones      (botones),
        .cmd_ready    (cmd_ready),
        .cmd_valid    (cmd_valid),
        .cmd_id       (cmd_id),
        .btn_rst      (btn_rst),
        .pending      (pending),
        .evt_drop     (evt_drop),
        .dbg_arb_state(dbg_arb_state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int rst_pulses = 0;
    int drop_pulses = 0;

    logic [1:0] exp_q[$];
    logic [1:0] obs_q[$];
    int         obs_cyc_q[$];

    // Reference model: accepted-but-unserved commands and arbitration pointer.
    logic [3:0] m_pending = 4'b0000;
    logic [1:0] m_last = 2'd3;
    int         m_drops = 0;
    int         m_rst = 0;

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic [1:0] prev_id = 2'd0;
    logic       prev_ok = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] rr_pick(input logic [3:0] pend, input logic [1:0] last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (int'(last) + k) % 4;
            if (pend[idx]) return 2'(idx);
        end
        return last;
    endfunction

    always @(posedge clk) cycle++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (cmd_valid && cmd_ready) begin
                obs_q.push_back(cmd_id);
                obs_cyc_q.push_back(cycle);
            end
            if (btn_rst) begin
                rst_pulses++;
                check("rst_clears_pending", {28'd0, pending}, 32'd0);
            end
            if (evt_drop) drop_pulses++;
            if (prev_ok && prev_valid && !prev_ready && !btn_rst) begin
                check("offer_stable", {29'd0, cmd_valid, cmd_id}, {29'd0, 1'b1, prev_id});
            end
        end
        prev_valid = cmd_valid;
        prev_ready = cmd_ready;
        prev_id    = cmd_id;
        prev_ok    = rst_n;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input logic [3:0] mask, input int ticks);
        botones = botones | mask;
        step(ticks * TICK_MAX);
        botones = botones & ~mask;
    endtask

    task automatic settle();
        step((DEBOUNCE_MS + 2) * TICK_MAX);
    endtask

    task automatic model_press(input logic [3:0] mask);
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                if (m_pending[i]) m_drops++;
                m_pending[i] = 1'b1;
            end
        end
    endtask

    task automatic drain(input int max_cycles, input bit rand_ready);
        logic [1:0] p;
        int n;
        while (m_pending != 4'b0000) begin
            p = rr_pick(m_pending, m_last);
            exp_q.push_back(p);
            m_pending[p] = 1'b0;
            m_last = p;
        end
        n = 0;
        while ((cmd_valid || (pending != 4'b0000)) && (n < max_cycles)) begin
            cmd_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            step(1);
            n++;
        end
        cmd_ready = 1'b0;
        step(2);
        check("drain_idle", {27'd0, cmd_valid, pending}, 32'd0);
        check("grant_count", obs_q.size(), exp_q.size());
        while ((obs_q.size() > 0) && (exp_q.size() > 0)) begin
            check("grant_id", {30'd0, obs_q.pop_front()}, {30'd0, exp_q.pop_front()});
        end
        obs_q.delete();
        exp_q.delete();
        obs_cyc_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] mask;
        int         ticks;

        // Reset values
        step(3);
        check("rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_id", {30'd0, cmd_id}, 32'd0);
        check("rst_btn_rst", {31'd0, btn_rst}, 32'd0);
        check("rst_pending", {28'd0, pending}, 32'd0);
        check("rst_drop", {31'd0, evt_drop}, 32'd0);
        check("rst_state", {31'd0, dbg_arb_state}, 32'd0);
        #3 rst_n = 1'b1;
        step(5);

        // Debounce reject: 2-tick glitch on bit 1
        press(4'b0010, 2);
        settle();
        check("glitch_pending", {28'd0, pending}, 32'd0);
        check("glitch_valid", {31'd0, cmd_valid}, 32'd0);

        // Single press on bit 2, held offer, then one ready pulse
        press(4'b0100, 5);
        model_press(4'b0100);
        settle();
        check("single_pending", {28'd0, pending}, {28'd0, m_pending});
        check("single_valid", {31'd0, cmd_valid}, 32'd1);
        check("single_id", {30'd0, cmd_id}, {30'd0, rr_pick(m_pending, m_last)});
        check("single_state", {31'd0, dbg_arb_state}, 32'd1);
        step(7);
        check("single_id_held", {30'd0, cmd_id}, 32'd2);
        cmd_ready = 1'b1;
        step(1);
        cmd_ready = 1'b0;
        check("single_hs_pending", {28'd0, pending}, 32'd0);
        check("single_hs_valid", {31'd0, cmd_valid}, 32'd0);
        drain(50, 1'b0);

        // Round-robin: make bit 1 the last grant, then 1,2,3 together
        press(4'b0010, 5);
        model_press(4'b0010);
        settle();
        drain(50, 1'b0);
        cmd_ready = 1'b1;
        press(4'b1110, 5);
        model_press(4'b1110);
        settle();
        check("rr_count", obs_cyc_q.size(), 32'd3);
        if (obs_cyc_q.size() == 3) begin
            check("rr_gap1", obs_cyc_q[1] - obs_cyc_q[0], 32'd2);
            check("rr_gap2", obs_cyc_q[2] - obs_cyc_q[1], 32'd2);
        end
        drain(50, 1'b0);

        // Drop: bit 3 pressed twice while the game is not ready
        press(4'b1000, 5);
        model_press(4'b1000);
        settle();
        press(4'b1000, 5);
        model_press(4'b1000);
        settle();
        check("drop_count", drop_pulses, m_drops);
        check("drop_pending", {28'd0, pending}, {28'd0, m_pending});
        drain(50, 1'b0);

        // Short press on bit 0 becomes a select command
        press(4'b0001, 6);
        model_press(4'b0001);
        settle();
        check("short_pending", {28'd0, pending}, {28'd0, m_pending});
        check("short_no_rst", rst_pulses, m_rst);
        check("short_id", {30'd0, cmd_id}, {30'd0, rr_pick(m_pending, m_last)});
        drain(50, 1'b0);

        // Long press while bit 1 is offered
        press(4'b0010, 5);
        model_press(4'b0010);
        settle();
        check("long_pre_valid", {31'd0, cmd_valid}, 32'd1);
        check("long_pre_id", {30'd0, cmd_id}, {30'd0, rr_pick(m_pending, m_last)});
        press(4'b0001, 12);
        settle();
        m_rst++;
        m_pending = 4'b0000;
        check("long_rst_count", rst_pulses, m_rst);
        check("long_pending", {28'd0, pending}, 32'd0);
        check("long_valid", {31'd0, cmd_valid}, 32'd0);
        drain(50, 1'b0);

        // Very long hold still fires only once
        press(4'b0001, 20);
        settle();
        m_rst++;
        check("sat_rst_count", rst_pulses, m_rst);
        check("sat_pending", {28'd0, pending}, 32'd0);
        check("drop_total", drop_pulses, m_drops);

        // Asynchronous reset in the middle of an offer
        press(4'b0100, 5);
        settle();
        check("ar_pre_valid", {31'd0, cmd_valid}, 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("ar_valid", {31'd0, cmd_valid}, 32'd0);
        check("ar_pending", {28'd0, pending}, 32'd0);
        check("ar_id", {30'd0, cmd_id}, 32'd0);
        m_pending = 4'b0000;
        m_last = 2'd3;
        obs_q.delete();
        obs_cyc_q.delete();
        step(2);
        #2 rst_n = 1'b1;
        step(3);
        botones[0] = 1'b1;
        step(5 * TICK_MAX);
        botones[0] = 1'b0;
        botones[1] = 1'b1;
        step(5 * TICK_MAX);
        botones[1] = 1'b0;
        model_press(4'b0011);
        settle();
        check("ar_both_pending", {28'd0, pending}, {28'd0, m_pending});
        check("ar_first_id", {30'd0, cmd_id}, {30'd0, rr_pick(m_pending, m_last)});
        drain(50, 1'b0);

        // Randomized press rounds with random ready during drain
        for (int r = 0; r < 8; r++) begin
            mask = 4'($urandom_range(1, 7)) << 1;
            ticks = $urandom_range(1, 6);
            press(mask, ticks);
            if (ticks >= DEBOUNCE_MS) model_press(mask);
            settle();
            if ($urandom_range(0, 1) == 1) begin
                mask = 4'($urandom_range(1, 7)) << 1;
                ticks = $urandom_range(1, 6);
                press(mask, ticks);
                if (ticks >= DEBOUNCE_MS) model_press(mask);
                settle();
            end
            check("rand_pending", {28'd0, pending}, {28'd0, m_pending});
            check("rand_drops", drop_pulses, m_drops);
            drain(400, 1'b1);
        end
        check("final_rst_count", rst_pulses, m_rst);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/bttn_scheduler.md
# bttn_scheduler

Input controller for the pet-game button panel. Synchronises and debounces four raw push-buttons on a shared millisecond time base. Converts presses into queued commands and hands them one at a time to the game FSM over a valid/ready handshake, using round-robin arbitration. Also detects a long press on button 0 and issues a game reset pulse, which flushes the queue.

## Interface
- `TICK_MAX`, 50000: clk cycles per time-base tick (1 ms at 50 MHz); ≥2.
- `DEBOUNCE_MS`, 20: consecutive ticks a raw level must disagree with the debounced level before it is accepted; ≥1.
- `LONG_MS`, 5000: ticks button 0 must be held (debounced) to fire `btn_rst`; > `DEBOUNCE_MS`.
- `clk` in 1: system clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `botones` in 4: raw buttons, active-high, asynchronous to `clk`. Bit 0 is select/reset; bits 1–3 are actions.
- `cmd_ready` in 1: game FSM accepts the offered command.
- `cmd_valid` out 1: a command is offered.
- `cmd_id` out 2: index of the offered button.
- `btn_rst` out 1: one-cycle game reset pulse on a long press.
- `pending` out 4: queued-but-unaccepted command bits.
- `evt_drop` out 1: one-cycle pulse when a press hits an already-pending bit.

## Operation
- **Prescaler:** counter 0..`TICK_MAX`-1 wraps. `tick` is a one-cycle internal pulse on wrap.
- **Sync:** each `botones` bit passes through a 2-FF synchroniser.
- **Debounce, per bit:**
  - The counter increments on each `tick` where the synced level differs from the debounced level.
  - The counter clears on any `tick` where they agree.
  - On reaching `DEBOUNCE_MS`, the debounced level toggles and the counter clears.
- **Action bits 1–3:** a debounced rising edge sets `pending[i]`. If the bit is already set, it stays set and `evt_drop` pulses.
- **Bit 0 hold counter:**
  - Clears while the debounced level is 0.
  - While the level is 1, increments per `tick`, saturating at `LONG_MS`.
  - When it reaches `LONG_MS`: `btn_rst` pulses once, all `pending` bits clear, and a `long_seen` flag sets.
  - On debounced fall: if `long_seen`=0, set `pending[0]` (short press = select command, with drop rule as above). Clear `long_seen`.
- **Arbiter FSM, IDLE state:**
  - If `pending`≠0, pick the first set bit searching from `last_grant+1` mod 4 upward with wrap.
  - Register `cmd_id` and `cmd_valid`=1, then go to OFFER.
- **Arbiter FSM, OFFER state:**
  - `cmd_valid`/`cmd_id` are held stable until `cmd_ready`=1.
  - On handshake: clear `pending[cmd_id]`, set `last_grant`=`cmd_id`, drop `cmd_valid`, return to IDLE.
- **Simultaneous events:**
  - A new press on bit k in the same cycle as the handshake of bit k: the bit stays set, no `evt_drop`.
  - `btn_rst` in any state: pending is cleared (new presses that same cycle are discarded). In OFFER, `cmd_valid` drops next cycle without handshake and the FSM returns to IDLE. This is the only case in which `valid` may be withdrawn.
  - `btn_rst` fires only once per hold. The hold counter stays saturated until release.
- **Reset:** `rst_n` low clears all state asynchronously.

## Timing
- **Reset values:**
  - `cmd_valid`=0, `cmd_id`=0, `btn_rst`=0, `pending`=0, `evt_drop`=0.
  - Debounced levels 0, all counters 0, `last_grant`=3 (so bit 0 has first priority), `long_seen`=0, FSM in IDLE.
- **Press latency:** 2 cycles sync, plus `DEBOUNCE_MS` ticks (first tick phase varies up to `TICK_MAX`-1 cycles), plus 1 cycle to `pending`, plus 1 cycle to `cmd_valid`.
- **Throughput:** at most one handshake per 2 cycles (IDLE cycle between grants).
- **Long-press latency:** `btn_rst` is asserted in the cycle after the tick on which the hold counter reaches `LONG_MS`. `pending` reads 0 in the same cycle.
- Prescaler and debounce keep running during OFFER. Events are never lost except by the drop rule or `btn_rst`.
- Mid-operation `rst_n`: outputs go to their reset values immediately, independent of `clk`.

## Test plan
Use `TICK_MAX`=4, `DEBOUNCE_MS`=3, `LONG_MS`=10 for all scenarios.
- **Debounce reject:** `botones[1]` glitches high for 2 ticks, then low → `pending` stays 0, `cmd_valid` stays 0.
- **Single press:** hold `botones[2]` for 5 ticks with `cmd_ready`=0 → `pending`=4'b0100, `cmd_valid`=1, `cmd_id`=2 held stable. Pulse `cmd_ready` → `pending`=0, `cmd_valid`=0 next cycle.
- **Round-robin:** bits 1, 2, 3 pending at once, `cmd_ready`=1 constantly, `last_grant`=1 → grants in order 2, 3, 1, spaced 2 cycles apart.
- **Drop:** press bit 3 twice with `cmd_ready`=0 → one `evt_drop` pulse on the second debounced rise, `pending[3]`=1.
- **Short vs long:**
  - Bit 0 held 6 ticks, then released → `pending[0]`=1 after release, no `btn_rst`.
  - Bit 0 held 12 ticks while bit 1 is pending and offered → exactly one `btn_rst` pulse, `pending`=0, `cmd_valid` drops, no `pending[0]` on release.
- **Async reset:** assert `rst_n`=0 mid-OFFER between clock edges → `cmd_valid`=0 and `pending`=0 immediately. After release, the first grant from pending {0,1} is `cmd_id`=0.
